// File: rtl/bcd_pkg.sv
// Shared BCD constants and the digit clamp used when loading out-of-range values.
package bcd_pkg;

   localparam int        BCD_W   = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] digit);
      return (digit > BCD_MAX) ? BCD_MAX : digit;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the event counter: load, up/down count with roll-over,
// and a terminal flag the top level chains into lookahead carry/borrow.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_up,
   input  logic             i_load,
   input  logic [BCD_W-1:0] i_load_val,
   input  logic             i_cin,
   output logic [BCD_W-1:0] o_digit,
   output logic             o_terminal
);

   logic [BCD_W-1:0] r_digit;
   logic [BCD_W-1:0] w_next;

   // NOTE: every signal driven from always_comb gets a value on all paths
   // (here via the ternaries) so no latch is inferred.
   always_comb begin
      w_next = r_digit;
      if (i_up) w_next = (r_digit == BCD_MAX) ? BCD_MIN : r_digit + 4'd1;
      else      w_next = (r_digit == BCD_MIN) ? BCD_MAX : r_digit - 4'd1;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all digits
   // sample each other's pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)               r_digit <= BCD_MIN;
      else if (i_load)            r_digit <= bcd_clamp(i_load_val);
      else if (i_en && i_cin)     r_digit <= w_next;
   end

   assign o_digit    = r_digit;
   assign o_terminal = i_up ? (r_digit == BCD_MAX) : (r_digit == BCD_MIN);

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD event counter with wrap/saturate, carry pulse, sticky overflow
// and a display-hold snapshot register.
module bcd_counter_n
   import bcd_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter bit WRAP_EN    = 1'b1
) (
   input  logic                        F_IN,
   input  logic                        CLR_N,
   input  logic                        ENA,
   input  logic                        UP,
   input  logic                        LOAD,
   input  logic [BCD_W*NUM_DIGITS-1:0] LOAD_VAL,
   input  logic                        LATCH,
   output logic [BCD_W*NUM_DIGITS-1:0] Q,
   output logic [BCD_W*NUM_DIGITS-1:0] Q_HOLD,
   output logic                        CARRY,
   output logic                        OVF
);

   localparam int W = BCD_W * NUM_DIGITS;

   logic [NUM_DIGITS-1:0] w_term;
   logic [NUM_DIGITS-1:0] w_cin;
   logic                  w_all_term;
   logic                  w_term_evt;
   logic                  w_count_en;

   logic [W-1:0] r_hold;
   logic         r_carry;
   logic         r_ovf;

   // Lookahead: digit i moves only when every lower digit is at its terminal value.
   always_comb begin
      w_cin[0] = ENA;
      for (int i = 1; i < NUM_DIGITS; i++) w_cin[i] = w_cin[i-1] & w_term[i-1];
   end

   assign w_all_term = &w_term;
   assign w_term_evt = ENA & ~LOAD & w_all_term;
   // Saturating build freezes every digit at the terminal count.
   assign w_count_en = ~(w_all_term & ~WRAP_EN);

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .i_clk      (F_IN),
         .i_rst_n    (CLR_N),
         .i_en       (w_count_en),
         .i_up       (UP),
         .i_load     (LOAD),
         .i_load_val (LOAD_VAL[BCD_W*g +: BCD_W]),
         .i_cin      (w_cin[g]),
         .o_digit    (Q[BCD_W*g +: BCD_W]),
         .o_terminal (w_term[g])
      );
   end

   always_ff @(posedge F_IN or negedge CLR_N) begin
      if (!CLR_N) begin
         r_hold  <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (LATCH) r_hold <= Q;
         r_carry <= w_term_evt & WRAP_EN;
         // A terminal event on the latching edge wins over the clear.
         if (w_term_evt) r_ovf <= 1'b1;
         else if (LATCH) r_ovf <= 1'b0;
      end
   end

   assign Q_HOLD = r_hold;
   assign CARRY  = r_carry;
   assign OVF    = r_ovf;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench: 6-digit wrapping counter driven from a vector table, plus a
// 2-digit saturating instance and hand-written reset/saturate sequences.
module tb_bcd_counter_n;

   logic        F_IN = 1'b0;
   logic        CLR_N, ENA, UP, LOAD, LATCH;
   logic [23:0] LOAD_VAL;
   logic [7:0]  LOAD_VAL2;
   logic [23:0] Q, Q_HOLD;
   logic [7:0]  Q2, Q_HOLD2;
   logic        CARRY, OVF, CARRY2, OVF2;

   int total = 0;
   int bad   = 0;

   always #5 F_IN = ~F_IN;

   bcd_counter_n #(.NUM_DIGITS(6), .WRAP_EN(1'b1)) dut (
      .F_IN(F_IN), .CLR_N(CLR_N), .ENA(ENA), .UP(UP), .LOAD(LOAD),
      .LOAD_VAL(LOAD_VAL), .LATCH(LATCH), .Q(Q), .Q_HOLD(Q_HOLD),
      .CARRY(CARRY), .OVF(OVF)
   );

   bcd_counter_n #(.NUM_DIGITS(2), .WRAP_EN(1'b0)) dut_sat (
      .F_IN(F_IN), .CLR_N(CLR_N), .ENA(ENA), .UP(UP), .LOAD(LOAD),
      .LOAD_VAL(LOAD_VAL2), .LATCH(LATCH), .Q(Q2), .Q_HOLD(Q_HOLD2),
      .CARRY(CARRY2), .OVF(OVF2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        ena, up, load, latch;
      logic [23:0] lv;
      logic [23:0] q, hold;
      logic        carry, ovf;
   } vec_t;

   vec_t vecs[17];

   task automatic drive(input logic ena, input logic up, input logic load, input logic latch);
      @(negedge F_IN);
      ENA = ena; UP = up; LOAD = load; LATCH = latch;
      @(posedge F_IN);
      #1;
   endtask

   initial begin
      //            ena  up  load latch lv          q           hold        c  ovf
      vecs[0]  = '{1'b0,1'b0,1'b1,1'b0, 24'h099999, 24'h099999, 24'h000000, 0, 0};
      vecs[1]  = '{1'b1,1'b1,1'b0,1'b0, 24'h000000, 24'h100000, 24'h000000, 0, 0};
      vecs[2]  = '{1'b1,1'b0,1'b0,1'b0, 24'h000000, 24'h099999, 24'h000000, 0, 0};
      vecs[3]  = '{1'b0,1'b1,1'b1,1'b0, 24'h999999, 24'h999999, 24'h000000, 0, 0};
      vecs[4]  = '{1'b1,1'b1,1'b0,1'b0, 24'h000000, 24'h000000, 24'h000000, 1, 1};
      vecs[5]  = '{1'b0,1'b1,1'b0,1'b0, 24'h000000, 24'h000000, 24'h000000, 0, 1};
      vecs[6]  = '{1'b1,1'b0,1'b0,1'b0, 24'h000000, 24'h999999, 24'h000000, 1, 1};
      vecs[7]  = '{1'b0,1'b1,1'b1,1'b0, 24'hA3F012, 24'h939012, 24'h000000, 0, 1};
      vecs[8]  = '{1'b1,1'b1,1'b0,1'b1, 24'h000000, 24'h939013, 24'h939012, 0, 0};
      vecs[9]  = '{1'b0,1'b1,1'b1,1'b0, 24'h000009, 24'h000009, 24'h939012, 0, 0};
      vecs[10] = '{1'b1,1'b1,1'b0,1'b0, 24'h000000, 24'h000010, 24'h939012, 0, 0};
      vecs[11] = '{1'b0,1'b1,1'b1,1'b1, 24'h000000, 24'h000000, 24'h000010, 0, 0};
      vecs[12] = '{1'b1,1'b0,1'b0,1'b1, 24'h000000, 24'h999999, 24'h000000, 1, 1};
      vecs[13] = '{1'b0,1'b0,1'b0,1'b1, 24'h000000, 24'h999999, 24'h999999, 0, 0};
      vecs[14] = '{1'b0,1'b1,1'b1,1'b0, 24'hFFFFFF, 24'h999999, 24'h999999, 0, 0};
      vecs[15] = '{1'b1,1'b1,1'b1,1'b0, 24'h123456, 24'h123456, 24'h999999, 0, 0};
      vecs[16] = '{1'b0,1'b1,1'b0,1'b0, 24'h000000, 24'h123456, 24'h999999, 0, 0};

      CLR_N = 1'b0; ENA = 1'b0; UP = 1'b1; LOAD = 1'b0; LATCH = 1'b0;
      LOAD_VAL = '0; LOAD_VAL2 = '0;
      repeat (3) @(posedge F_IN);
      #1;
      check("reset_q", Q, 0);
      check("reset_hold", Q_HOLD, 0);
      check("reset_carry", CARRY, 0);
      check("reset_ovf", OVF, 0);
      @(negedge F_IN);
      CLR_N = 1'b1;

      // 15 up edges from reset
      for (int i = 0; i < 15; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0);
         check("count_carry", CARRY, 0);
      end
      check("count15_q", Q, 24'h000015);
      check("count15_ovf", OVF, 0);

      for (int i = 0; i < 17; i++) begin
         LOAD_VAL = vecs[i].lv;
         drive(vecs[i].ena, vecs[i].up, vecs[i].load, vecs[i].latch);
         check($sformatf("vec%0d_q", i), Q, vecs[i].q);
         check($sformatf("vec%0d_hold", i), Q_HOLD, vecs[i].hold);
         check($sformatf("vec%0d_carry", i), CARRY, vecs[i].carry);
         check($sformatf("vec%0d_ovf", i), OVF, vecs[i].ovf);
      end

      // Saturating 2-digit instance: 98 -> 99 then held, OVF set, no carry
      LOAD_VAL2 = 8'h98;
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      check("sat_load", Q2, 8'h98);
      check("sat_load_ovf", OVF2, 0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      check("sat_e1_q", Q2, 8'h99);
      check("sat_e1_ovf", OVF2, 0);
      check("sat_e1_carry", CARRY2, 0);
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0);
         check("sat_hold_q", Q2, 8'h99);
         check("sat_hold_ovf", OVF2, 1);
         check("sat_hold_carry", CARRY2, 0);
      end
      // Saturate at zero counting down
      LOAD_VAL2 = 8'h01;
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      check("satdn_load_ovf", OVF2, 0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check("satdn_e1_q", Q2, 8'h00);
      check("satdn_e1_ovf", OVF2, 0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check("satdn_e2_q", Q2, 8'h00);
      check("satdn_e2_ovf", OVF2, 1);
      check("satdn_e2_carry", CARRY2, 0);

      // Mid-count asynchronous clear: outputs drop without a clock edge
      LOAD_VAL = 24'h999999;
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      check("pre_clr_carry", CARRY, 1);
      #2;
      CLR_N = 1'b0;
      #1;
      check("clr_q", Q, 0);
      check("clr_hold", Q_HOLD, 0);
      check("clr_carry", CARRY, 0);
      check("clr_ovf", OVF, 0);
      check("clr_q2", Q2, 0);
      check("clr_ovf2", OVF2, 0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      check("clr_held_q", Q, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
Parametrised N-digit BCD event counter: the next-generation counting core for the frequency-meter datapath.
- Counts rising edges of F_IN, up or down, with synchronous parallel load.
- Wrap or saturate at the terminal count, with a carry pulse and a sticky overflow flag.
- LATCH snapshots the live count into a display-hold register, so the display stays stable while counting continues.

Parameters:
- NUM_DIGITS, 6: number of BCD digits; count width is 4*NUM_DIGITS; legal range 1..8.
- WRAP_EN, 1: 1 = wrap at terminal count; 0 = saturate at terminal count.

Ports:
- F_IN  input  1  counting clock; all state updates on its rising edge.
- CLR_N  input  1  asynchronous active-low reset.
- ENA  input  1  count enable; sampled on each F_IN rising edge.
- UP  input  1  direction; 1 = increment, 0 = decrement.
- LOAD  input  1  synchronous parallel load strobe.
- LOAD_VAL  input  4*NUM_DIGITS  value to load; digit i is LOAD_VAL[4i+3:4i].
- LATCH  input  1  snapshot strobe; also clears OVF.
- Q  output  4*NUM_DIGITS  live BCD count; digit 0 is the least significant.
- Q_HOLD  output  4*NUM_DIGITS  latched BCD count for display.
- CARRY  output  1  one-cycle pulse on wrap.
- OVF  output  1  sticky terminal-count-exceeded flag.

Behaviour:
- Reset (CLR_N=0, asynchronous): Q=0, Q_HOLD=0, CARRY=0, OVF=0. Holds while CLR_N is low. Reset mid-count discards everything.
- Deassertion of CLR_N is synchronised externally; the block assumes a clean release.
- Priority on each edge: LOAD > ENA count > hold.
- LOAD=1:
  - Q <= LOAD_VAL, digit by digit.
  - Any digit >9 is clamped to 9.
  - CARRY=0; OVF unchanged.
- ENA=1, UP=1 (increment):
  - Digit i increments when all lower digits are 9; a digit at 9 rolls to 0.
  - At all-9s with WRAP_EN=1: Q <= 0, CARRY=1 for one cycle, OVF <= 1.
  - At all-9s with WRAP_EN=0: Q holds, CARRY=0, OVF <= 1.
- ENA=1, UP=0 (decrement):
  - Digit i decrements when all lower digits are 0; a digit at 0 rolls to 9.
  - At all-0s with WRAP_EN=1: Q <= all-9s, CARRY=1, OVF <= 1.
  - At all-0s with WRAP_EN=0: Q holds at 0, OVF <= 1.
- ENA=0 and LOAD=0: Q holds; CARRY=0.
- CARRY is registered, high exactly for the cycle following the wrapping edge; otherwise 0.
- LATCH=1:
  - Q_HOLD <= Q as it was before this edge's update, so a simultaneous count is not captured.
  - OVF <= 0, unless a terminal event occurs on the same edge; then OVF <= 1 (new event wins).
- LATCH with LOAD on the same edge: Q_HOLD gets the pre-load Q.
- Latency: Q, CARRY, OVF and Q_HOLD all update one F_IN edge after the sampled inputs. No combinational input-to-output paths.
- Q never holds a non-BCD digit. Ripple is resolved within one cycle as combinational carry/borrow lookahead across digits.

Decomposition:
- Package bcd_pkg:
  - BCD_W=4, BCD_MAX=4'd9, BCD_MIN=4'd0.
  - Function bcd_clamp(digit) returning min(digit, 9).
- Sub-module bcd_digit, instantiated NUM_DIGITS times via generate:
  - Inputs: en, up, load, load_val, cin.
  - Outputs: digit value, terminal (9 when up, 0 when down).
  - Top-level chaining: cin of digit i = AND of terminal of digits 0..i-1, ANDed with ENA.
- Top level owns CARRY/OVF/Q_HOLD, the WRAP_EN saturate gating and priority logic.

Test Plan:
- Reset and count: CLR_N low then high, ENA=1, UP=1, 15 edges -> Q=24'h000015, CARRY never high, OVF=0.
- Digit ripple: LOAD_VAL=24'h099999, LOAD, then 1 up edge -> Q=24'h100000.
- Wrap up: LOAD 24'h999999, then 1 up edge -> Q=0, CARRY=1 for one cycle, OVF=1.
- Wrap down (WRAP_EN=1): from Q=0, UP=0, 1 edge -> Q=24'h999999, CARRY pulse, OVF=1.
- Saturate (WRAP_EN=0, NUM_DIGITS=2): LOAD 8'h98, 3 up edges -> Q=8'h99 held, OVF=1, CARRY=0 throughout.
- Latch and clamp:
  - LOAD_VAL=24'hA3F012 -> Q=24'h939012.
  - Then LATCH with ENA=1 -> Q_HOLD=24'h939012, Q=24'h939013, OVF cleared.
  - CLR_N pulse mid-count -> all outputs 0 immediately.
